// File: rtl/banded_sw_scorer_if.sv
// Request/result bundle for banded_sw_scorer.
// master drives start/R/Q; slave returns status and results.
interface banded_sw_scorer_if #(
   parameter int LEN = 12,
   parameter int SW  = 8
);
   localparam int AW = $clog2(LEN + 1);

   logic             start;
   logic [2*LEN-1:0] R;
   logic [2*LEN-1:0] Q;
   logic             busy;
   logic             done;
   logic [SW-1:0]    score;
   logic [AW-1:0]    end_r;
   logic [AW-1:0]    end_q;
   logic             early;

   modport master (
      output start, R, Q,
      input  busy, done, score, end_r, end_q, early
   );

   modport slave (
      input  start, R, Q,
      output busy, done, score, end_r, end_q, early
   );
endinterface

// File: rtl/banded_sw_scorer.sv
// Banded Smith-Waterman scorer, one DP cell per cycle.
// Optional X-drop early exit: define SW_EARLY_EXIT_EN.
module banded_sw_scorer #(
   parameter int LEN      = 12,
   parameter int BAND     = 2,
   parameter int SW       = 8,
   parameter int MATCH    = 2,
   parameter int MISMATCH = 1,
   parameter int GAP      = 1,
   parameter int XDROP    = 6
) (
   input logic clk,
   input logic reset,
   banded_sw_scorer_if.slave bus
);
   localparam int AW = $clog2(LEN + 1);
   localparam int XW = (LEN > 1) ? $clog2(LEN) : 1;
   localparam int NB = 2 * BAND + 1;
   localparam int DW = $clog2(NB + 1);
   localparam int IW = SW + 2;
   localparam logic [SW-1:0] SMAX = {SW{1'b1}};
   localparam logic [AW-1:0] LEN_A = AW'(LEN);
   localparam logic [AW-1:0] ONE_A = AW'(1);
   localparam logic [DW-1:0] DTOP = DW'(2 * BAND);

   typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;
   state_t state_q, state_d;

   logic [1:0]    rs_q [LEN];
   logic [1:0]    qs_q [LEN];
   logic [AW-1:0] i_q, j_q;
   logic [DW-1:0] d_q;
   logic [SW-1:0] row_q [NB];
   logic [SW-1:0] left_q;
   logic          stop_q;
   logic          hv_q;
   logic [SW-1:0] h_q;
   logic [AW-1:0] hi_q, hj_q;
   logic [SW-1:0] best_q;
   logic [AW-1:0] bi_q, bj_q;
   logic [SW-1:0] score_q;
   logic [AW-1:0] er_q, eq_q;

   logic go, fin_go, cell_en;
   logic row_end, last, stop_set;
   logic [AW-1:0] jn;
   logic [DW-1:0] dn, du;
   logic [XW-1:0] ri, qj;
   logic [SW-1:0] diag, up, h_cell;
   logic signed [IW-1:0] vd, vu, vl, vm;
   logic          upd;
   logic [SW-1:0] nb_s;
   logic [AW-1:0] nb_i, nb_j;

   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (bus.start) state_d = CALC;
         CALC:    if (stop_q) state_d = FIN;
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.busy = 1'b0;
      bus.done = 1'b0;
      unique case (1'b1)
         (state_q == CALC): bus.busy = 1'b1;
         (state_q == FIN):  bus.done = 1'b1;
         default: ;
      endcase
   end

   assign go      = (state_q == IDLE) && bus.start;
   assign fin_go  = (state_q == CALC) && stop_q;
   assign cell_en = (state_q == CALC) && !stop_q;
   assign row_end = (j_q == LEN_A) || (d_q == DTOP);
   assign last    = row_end && (i_q == LEN_A);

   // First cell of the next row, and its diagonal slot
   assign jn = (int'(i_q) >= BAND) ? AW'(int'(i_q) + 1 - BAND) : ONE_A;
   assign dn = (int'(i_q) >= BAND) ? '0 : DW'(BAND - int'(i_q));
   assign du = (d_q == DTOP) ? d_q : d_q + 1'b1;

   always_comb begin
      ri   = XW'(i_q - ONE_A);
      qj   = XW'(j_q - ONE_A);
      diag = (i_q == ONE_A || j_q == ONE_A) ? '0 : row_q[d_q];
      up   = (i_q == ONE_A || d_q == DTOP) ? '0 : row_q[du];
      vd   = signed'({2'b00, diag});
      vd   = vd + ((rs_q[ri] == qs_q[qj]) ? IW'(MATCH) : -IW'(MISMATCH));
      vu   = signed'({2'b00, up}) - IW'(GAP);
      vl   = signed'({2'b00, left_q}) - IW'(GAP);
      vm   = '0;
      if (vd > vm) vm = vd;
      if (vu > vm) vm = vu;
      if (vl > vm) vm = vl;
      h_cell = (vm > signed'({2'b00, SMAX})) ? SMAX : vm[SW-1:0];
   end

   // Max fold lags the cell by one cycle; ties keep the earlier cell
   always_comb begin
      upd  = hv_q && (h_q > best_q);
      nb_s = upd ? h_q : best_q;
      nb_i = upd ? hi_q : bi_q;
      nb_j = upd ? hj_q : bj_q;
   end

   always_ff @(posedge clk) begin
      if (go) begin
         for (int k = 0; k < LEN; k++) begin
            rs_q[k] <= bus.R[2*k +: 2];
            qs_q[k] <= bus.Q[2*k +: 2];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < NB; k++) row_q[k] <= '0;
         i_q     <= ONE_A;
         j_q     <= ONE_A;
         d_q     <= DW'(BAND);
         left_q  <= '0;
         stop_q  <= 1'b0;
         hv_q    <= 1'b0;
         h_q     <= '0;
         hi_q    <= '0;
         hj_q    <= '0;
         best_q  <= '0;
         bi_q    <= '0;
         bj_q    <= '0;
         score_q <= '0;
         er_q    <= '0;
         eq_q    <= '0;
      end else begin
         hv_q <= cell_en;
         if (go) begin
            i_q     <= ONE_A;
            j_q     <= ONE_A;
            d_q     <= DW'(BAND);
            left_q  <= '0;
            stop_q  <= 1'b0;
            best_q  <= '0;
            bi_q    <= '0;
            bj_q    <= '0;
            score_q <= '0;
            er_q    <= '0;
            eq_q    <= '0;
         end else begin
            best_q <= nb_s;
            bi_q   <= nb_i;
            bj_q   <= nb_j;
            if (cell_en) begin
               h_q        <= h_cell;
               hi_q       <= i_q;
               hj_q       <= j_q;
               row_q[d_q] <= h_cell;
               if (stop_set) stop_q <= 1'b1;
               if (row_end) begin
                  left_q <= '0;
                  if (!last) begin
                     i_q <= i_q + ONE_A;
                     j_q <= jn;
                     d_q <= dn;
                  end
               end else begin
                  left_q <= h_cell;
                  j_q    <= j_q + ONE_A;
                  d_q    <= d_q + 1'b1;
               end
            end
            if (fin_go) begin
               score_q <= nb_s;
               er_q    <= nb_i;
               eq_q    <= nb_j;
            end
         end
      end
   end

   assign bus.score = score_q;
   assign bus.end_r = er_q;
   assign bus.end_q = eq_q;

`ifdef SW_EARLY_EXIT_EN
   logic [SW-1:0] rmax_q, rm, sm;
   logic          xdrop, xit_q, early_q;

   // Row max and global max both include the cell being computed
   always_comb begin
      rm    = (h_cell > rmax_q) ? h_cell : rmax_q;
      sm    = (h_cell > nb_s) ? h_cell : nb_s;
      xdrop = cell_en && row_end && !last &&
              ((IW'(rm) + IW'(XDROP)) < IW'(sm));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rmax_q  <= '0;
         xit_q   <= 1'b0;
         early_q <= 1'b0;
      end else if (go) begin
         rmax_q  <= '0;
         xit_q   <= 1'b0;
         early_q <= 1'b0;
      end else begin
         if (cell_en) rmax_q <= row_end ? '0 : rm;
         if (xdrop) xit_q <= 1'b1;
         if (fin_go) early_q <= xit_q;
      end
   end

   assign stop_set  = last | xdrop;
   assign bus.early = early_q;
`else
   assign stop_set  = last;
   assign bus.early = 1'b0;
`endif
endmodule

// File: doc/banded_sw_scorer.md
Name: banded_sw_scorer

Overview:
- Parametrised banded Smith-Waterman local-alignment scoring engine. It is the next generation of the fixed 12-base banded SW accelerator.
- Takes two 2-bit-encoded DNA sequences of LEN bases. Computes the band-limited DP matrix one cell per cycle and reports the best local score with its end coordinates.
- Sits beside the aligner. It shares the same sequence memory and the same start/ready-style handshake.
- Adds parametrised length, band and scoring, plus a done pulse, busy status and a deterministic cycle count.

Parameters:
- LEN, 12, bases per sequence (≥ 2).
- BAND, 2, half-band width. Cells with |i−j| ≤ BAND are computed.
- SW, 8, score width in bits, unsigned.
- MATCH, 2, reward added on a base match.
- MISMATCH, 1, penalty subtracted on a mismatch.
- GAP, 1, linear gap penalty.
- XDROP, 6, early-exit threshold; used only with the optional feature.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request. Sampled only in IDLE.
- R  in  2*LEN  reference sequence. Base k occupies bits [2k+1:2k]; k=0 is the first base. Encoding A=00, C=01, G=10, T=11.
- Q  in  2*LEN  query sequence, same encoding.
- busy  out  1  high while a computation is in progress.
- done  out  1  one-cycle pulse when results become valid.
- score  out  SW  best local score.
- end_r  out  clog2(LEN+1)  1-based row i of the best cell; 0 if score is 0.
- end_q  out  clog2(LEN+1)  1-based column j of the best cell; 0 if score is 0.
- early  out  1  run ended by early exit (optional feature; tied 0 otherwise).

Behaviour:
- Reset: one clk edge with reset=1 forces
  - state=IDLE;
  - busy, done, early, score, end_r, end_q = 0;
  - row buffer and max registers cleared.
- Reset mid-run aborts the run immediately. No done pulse is produced.
- States:
  - IDLE: wait for start. If start=1, latch R and Q, set i=1, j=max(1,i−BAND), busy=1, and go to CALC.
  - CALC: compute one cell (i,j) per cycle.
    - Advance j up to min(LEN,i+BAND).
    - At the end of a row, i=i+1 and j restarts at max(1,i−BAND).
    - After cell (LEN,LEN), go to FIN.
  - FIN: busy=0, done=1 for this cycle only, then go to IDLE.
- Result hold: score, end_r and end_q are updated on the FIN entry edge. They hold until the next start is accepted. busy goes low in the FIN cycle.
- Cell recurrence: H(i,j) = max(0, H(i−1,j−1)+s, H(i−1,j)−GAP, H(i,j−1)−GAP).
  - s = +MATCH if R[i−1]==Q[j−1], otherwise −MISMATCH.
  - Any neighbour outside the band, or with i=0 or j=0, reads as 0.
- Arithmetic: internal arithmetic is 1 bit wider and signed. An addition result above 2^SW−1 saturates to 2^SW−1. Results below 0 clamp to 0 via the max().
- Storage:
  - Previous-row buffer of 2*BAND+1 entries, indexed by diagonal d=j−i+BAND. H(i−1,j−1) reads index d; H(i−1,j) reads index d+1.
  - H(i,j−1) is held in a left register, reset to 0 at the start of each row.
- Max tracking: the best cell is replaced only on a strict greater-than in row-major scan order. Ties keep the earliest cell.
- Latency: let CELLS = number of in-band cells (54 for the defaults). With start accepted on edge E0, done is high in the cycle after edge E0+CELLS+1.
- start while busy or in FIN is ignored. R and Q changes during a run have no effect.

Optional Feature:
- Macro: SW_EARLY_EXIT_EN.
- Defined:
  - At each row end, if row_max + XDROP < score_max, go to FIN on the next edge and set early=1.
  - early clears when the next start is accepted.
  - Results reflect the cells computed up to that point.
- Undefined: no row_max logic; early tied to 0; the full band is always scanned.

Test Plan:
- Identity: R=Q=24'hE4E4E4 (ACGT×3), defaults → score=24, end_r=12, end_q=12, early=0.
- All mismatch: R=24'h000000 (A×12), Q=24'h555555 (C×12) → score=0, end_r=0, end_q=0.
- Off-diagonal: R=24'h393939 (CGTA×3), Q=24'hE4E4E4 → score=22, end_r=11, end_q=12.
- Timing and handshake:
  - done pulses exactly once, in the cycle after edge E0+55.
  - busy is high from after E0 through edge E0+54.
  - A second start pulsed at E0+10 is ignored: no extra done, results unchanged.
- Reset mid-run: assert reset at E0+20 → busy=0, done never pulses, outputs 0. A new start then gives the correct identity result.
- Early exit: R=24'h555500 (AAAACCCCCCCC), Q=24'hAAAA00 (AAAAGGGGGGGG).
  - With SW_EARLY_EXIT_EN: score=8, end_r=4, end_q=4, early=1, done before E0+55.
  - Without the macro: same score and ends, early=0, done after E0+55.
